// File: rtl/result_argmax_scan_pkg.sv
// -----------------------------------------------------------------------------
// result_argmax_scan_pkg
//   Shared definitions for the result arg-max scanner: default word width,
//   default vector length, and the scan FSM state encoding.
// -----------------------------------------------------------------------------
package result_argmax_scan_pkg;

    localparam int DATA_LEN_DEF = 18;

    // 32 outputs x 12 words per output from the network core.
    localparam int WORDS_DEF = 32 * 12;
    localparam int IDX_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/result_argmax_scan_argmax_cmp.sv
// -----------------------------------------------------------------------------
// result_argmax_scan_argmax_cmp
//   Combinational signed compare-and-select used by the arg-max scanner.
//   The candidate replaces the current best only when it is strictly greater,
//   so on a tie the earlier (lower) index is kept.
//
//   Ports:
//     cand_val / cand_idx : word under test and its index
//     best_val / best_idx : current running maximum
//     new_val  / new_idx  : running maximum after considering the candidate
// -----------------------------------------------------------------------------
module result_argmax_scan_argmax_cmp #(
    parameter int DATA_LEN = 18,
    parameter int IDX_W    = 9
) (
    input  logic [DATA_LEN-1:0] cand_val,
    input  logic [IDX_W-1:0]    cand_idx,
    input  logic [DATA_LEN-1:0] best_val,
    input  logic [IDX_W-1:0]    best_idx,
    output logic [DATA_LEN-1:0] new_val,
    output logic [IDX_W-1:0]    new_idx
);

    always_comb begin
        new_val = best_val;
        new_idx = best_idx;
        if ($signed(cand_val) > $signed(best_val)) begin
            new_val = cand_val;
            new_idx = cand_idx;
        end
    end

endmodule

// File: rtl/result_argmax_scan.sv
// -----------------------------------------------------------------------------
// result_argmax_scan
//   Walks the packed result vector of the network core one word per cycle and
//   reports the index and signed value of the largest word.
//
//   Ports:
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     start    : single-cycle request, samples data_in (accepted in IDLE only)
//     data_in  : WORDS packed signed words, word 0 at the LSBs
//     busy     : high while a scan is in progress (SCAN and DONE states)
//     done     : one-cycle pulse when max_idx/max_val are updated
//     max_idx  : index of the maximum word (lowest index on ties)
//     max_val  : value of the maximum word
//     checksum : (ARGMAX_CHECKSUM_EN only) sign-extended sum of all words
//
//   Optional feature macro: ARGMAX_CHECKSUM_EN
// -----------------------------------------------------------------------------
module result_argmax_scan
    import result_argmax_scan_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEF,
    parameter int WORDS    = WORDS_DEF,
    parameter int IDX_W    = IDX_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WORDS*DATA_LEN-1:0] data_in,
    output logic                      busy,
    output logic                      done,
    output logic [IDX_W-1:0]          max_idx,
`ifdef ARGMAX_CHECKSUM_EN
    output logic [DATA_LEN+IDX_W-1:0] checksum,
`endif
    output logic [DATA_LEN-1:0]       max_val
);

    localparam int               VEC_W    = WORDS * DATA_LEN;
    localparam logic [DATA_LEN-1:0] MOST_NEG = {1'b1, {(DATA_LEN-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    state_e                state_q,    state_d;
    logic [VEC_W-1:0]      shreg_q,    shreg_d;
    logic [IDX_W-1:0]      counter_q,  counter_d;
    logic [DATA_LEN-1:0]   best_val_q, best_val_d;
    logic [IDX_W-1:0]      best_idx_q, best_idx_d;
    logic [DATA_LEN-1:0]   max_val_q,  max_val_d;
    logic [IDX_W-1:0]      max_idx_q,  max_idx_d;
    logic                  done_q,     done_d;

    logic [DATA_LEN-1:0]   cmp_val;
    logic [IDX_W-1:0]      cmp_idx;

    // The word under test is always the low word of the shift register; its
    // index is the counter value.
    result_argmax_scan_argmax_cmp #(
        .DATA_LEN (DATA_LEN),
        .IDX_W    (IDX_W)
    ) u_cmp (
        .cand_val (shreg_q[DATA_LEN-1:0]),
        .cand_idx (counter_q),
        .best_val (best_val_q),
        .best_idx (best_idx_q),
        .new_val  (cmp_val),
        .new_idx  (cmp_idx)
    );

`ifdef ARGMAX_CHECKSUM_EN
    logic [DATA_LEN+IDX_W-1:0] sum_q,      sum_d;
    logic [DATA_LEN+IDX_W-1:0] checksum_q, checksum_d;
    logic [DATA_LEN+IDX_W-1:0] word_sext;

    assign word_sext = {{IDX_W{shreg_q[DATA_LEN-1]}}, shreg_q[DATA_LEN-1:0]};
`endif

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        counter_d  = counter_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        max_val_d  = max_val_q;
        max_idx_d  = max_idx_q;
        done_d     = 1'b0;
`ifdef ARGMAX_CHECKSUM_EN
        sum_d      = sum_q;
        checksum_d = checksum_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d    = data_in;
                    counter_d  = '0;
                    // Starting from the most negative value guarantees word 0
                    // is taken even if every word equals that value.
                    best_val_d = MOST_NEG;
                    best_idx_d = '0;
`ifdef ARGMAX_CHECKSUM_EN
                    sum_d      = '0;
`endif
                    state_d    = SCAN;
                end
            end
            SCAN: begin
                best_val_d = cmp_val;
                best_idx_d = cmp_idx;
                shreg_d    = shreg_q >> DATA_LEN;
                counter_d  = counter_q + IDX_W'(1);
`ifdef ARGMAX_CHECKSUM_EN
                sum_d      = sum_q + word_sext;
`endif
                if (counter_q == LAST_IDX) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                max_val_d  = best_val_q;
                max_idx_d  = best_idx_q;
                done_d     = 1'b1;
`ifdef ARGMAX_CHECKSUM_EN
                checksum_d = sum_q;
`endif
                state_d    = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            counter_q  <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            max_val_q  <= '0;
            max_idx_q  <= '0;
            done_q     <= 1'b0;
`ifdef ARGMAX_CHECKSUM_EN
            sum_q      <= '0;
            checksum_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            counter_q  <= counter_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            max_val_q  <= max_val_d;
            max_idx_q  <= max_idx_d;
            done_q     <= done_d;
`ifdef ARGMAX_CHECKSUM_EN
            sum_q      <= sum_d;
            checksum_q <= checksum_d;
`endif
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign max_idx = max_idx_q;
    assign max_val = max_val_q;
`ifdef ARGMAX_CHECKSUM_EN
    assign checksum = checksum_q;
`endif

endmodule

// File: tb/tb_result_argmax_scan.sv
// -----------------------------------------------------------------------------
// tb_result_argmax_scan
//   Directed bench for result_argmax_scan with hand-computed expectations.
//   Builds with or without ARGMAX_CHECKSUM_EN.
// -----------------------------------------------------------------------------
module tb_result_argmax_scan;

    localparam int DL    = 18;
    localparam int WORDS = 384;
    localparam int IW    = 9;
    localparam int VW    = WORDS * DL;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [VW-1:0] data_in;
    logic          busy;
    logic          done;
    logic [IW-1:0] max_idx;
    logic [DL-1:0] max_val;
`ifdef ARGMAX_CHECKSUM_EN
    logic [DL+IW-1:0] checksum;
`endif

    int err_cnt = 0;
    int chk_cnt = 0;

    logic [VW-1:0] vec;
    logic [VW-1:0] vec2;
    int done_at, busy_cnt, done_pulses;
    bit hit_reset;

    result_argmax_scan #(
        .DATA_LEN (DL),
        .WORDS    (WORDS),
        .IDX_W    (IW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .data_in  (data_in),
        .busy     (busy),
        .done     (done),
        .max_idx  (max_idx),
`ifdef ARGMAX_CHECKSUM_EN
        .checksum (checksum),
`endif
        .max_val  (max_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [DL-1:0] w);
        logic [VW-1:0] v;
        for (int i = 0; i < WORDS; i++) v[i*DL +: DL] = w;
        return v;
    endfunction

    // Pulses start with vector v. Negedge number j falls after posedge k+j,
    // where k is the start edge. Optionally re-pulses start with v2 at j ==
    // restart_at, or asserts rst_n at j == reset_at (returns right after).
    task automatic run_scan(input logic [VW-1:0] v, input int restart_at,
                            input logic [VW-1:0] v2, input int reset_at,
                            input int n_cyc);
        done_at     = -1;
        busy_cnt    = 0;
        done_pulses = 0;
        hit_reset   = 1'b0;
        @(negedge clk);
        start   = 1'b1;
        data_in = v;
        for (int j = 0; j < n_cyc; j++) begin
            @(negedge clk);
            if (j == 0) begin
                start   = 1'b0;
                data_in = ~v;      // changing input must not disturb the scan
            end
            if (j == restart_at) begin
                start   = 1'b1;
                data_in = v2;
            end
            if (j == restart_at + 1) start = 1'b0;
            if (j == reset_at) begin
                rst_n = 1'b0;
                #1;
                hit_reset = 1'b1;
                break;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_pulses++;
                if (done_at < 0) done_at = j;
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_done", 64'(done), 64'd0);
        check_eq("reset_idx",  64'(max_idx), 64'd0);
        check_eq("reset_val",  64'(max_val), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // All zeros: latency and busy length.
        run_scan('0, -10, '0, -10, 400);
        check_eq("zero_done_at", 64'(done_at), 64'd385);
        check_eq("zero_busy_len", 64'(busy_cnt), 64'd385);
        check_eq("zero_pulses", 64'(done_pulses), 64'd1);
        check_eq("zero_idx", 64'(max_idx), 64'd0);
        check_eq("zero_val", 64'(max_val), 64'd0);

        // All -1 except last word = 1.
        vec = fill(18'h3FFFF);
        vec[383*DL +: DL] = 18'd1;
        run_scan(vec, -10, '0, -10, 390);
        check_eq("last_idx", 64'(max_idx), 64'd383);
        check_eq("last_val", 64'(max_val), 64'd1);

        // Tie at max positive: lowest index wins.
        vec = '0;
        vec[5*DL +: DL]   = 18'h1FFFF;
        vec[200*DL +: DL] = 18'h1FFFF;
        run_scan(vec, -10, '0, -10, 390);
        check_eq("tie_idx", 64'(max_idx), 64'd5);
        check_eq("tie_val", 64'(max_val), 64'h1FFFF);

        // Most-negative background with one -5.
        vec = fill(18'h20000);
        vec[10*DL +: DL] = 18'h3FFFB;
        run_scan(vec, -10, '0, -10, 390);
        check_eq("neg_idx", 64'(max_idx), 64'd10);
        check_eq("neg_val", 64'(max_val), 64'h3FFFB);

        // Entirely most-negative: word 0 still selected.
        run_scan(fill(18'h20000), -10, '0, -10, 390);
        check_eq("minneg_idx", 64'(max_idx), 64'd0);
        check_eq("minneg_val", 64'(max_val), 64'h20000);

        // Ramp: word i = i.
        for (int i = 0; i < WORDS; i++) vec[i*DL +: DL] = DL'(i);
        run_scan(vec, -10, '0, -10, 390);
        check_eq("ramp_idx", 64'(max_idx), 64'd383);
        check_eq("ramp_val", 64'(max_val), 64'd383);
`ifdef ARGMAX_CHECKSUM_EN
        check_eq("ramp_checksum", 64'(checksum), 64'd73536);
`endif

        // Start during a scan is ignored.
        vec  = '0;
        vec[7*DL +: DL] = 18'd100;
        vec2 = '0;
        vec2[9*DL +: DL] = 18'd500;
        run_scan(vec, 50, vec2, -10, 450);
        check_eq("restart_done_at", 64'(done_at), 64'd385);
        check_eq("restart_pulses", 64'(done_pulses), 64'd1);
        check_eq("restart_idx", 64'(max_idx), 64'd7);
        check_eq("restart_val", 64'(max_val), 64'd100);

        // Reset mid-scan.
        vec = '0;
        vec[3*DL +: DL] = 18'd50;
        run_scan(vec, -10, '0, 100, 200);
        check_eq("abort_reached", 64'(hit_reset), 64'd1);
        check_eq("abort_busy", 64'(busy), 64'd0);
        check_eq("abort_done", 64'(done), 64'd0);
        check_eq("abort_idx", 64'(max_idx), 64'd0);
        check_eq("abort_val", 64'(max_val), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        done_pulses = 0;
        busy_cnt = 0;
        for (int j = 0; j < 400; j++) begin
            @(negedge clk);
            if (done) done_pulses++;
            if (busy) busy_cnt++;
        end
        check_eq("abort_no_done", 64'(done_pulses), 64'd0);
        check_eq("abort_idle", 64'(busy_cnt), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
